// File: rtl/multicore_pkg.sv
// Shared types and constants for the multicore controller and its host-side loader.
package multicore_pkg;

  localparam int unsigned WORD_W        = 16;
  localparam int unsigned DEFAULT_WORDS = 1024;

  typedef enum logic [2:0] {
    RECV,
    CHECK,
    HOLD,
    START,
    BURST
  } load_state_t;

endpackage

// File: rtl/load_buffer.sv
// Frame buffer: simple dual-port RAM, synchronous write, registered read.
// The read register clears whenever no read is issued, so its output is
// zero outside a burst and can drive the controller directly.
module load_buffer
  import multicore_pkg::*;
#(
  parameter int unsigned WORDS = DEFAULT_WORDS,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [WORDS];

  // Storage write; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read, forced to zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/load_burst_packer.sv
// Host byte loader: packs big-endian byte pairs into a frame of WORDS words,
// then replays the frame as one gap-free burst to the multicore controller.
// Optional feature: define LOAD_CHECKSUM_EN to require a trailing 16-bit
// frame checksum; bad frames are dropped and flagged on frame_err.
module load_burst_packer
  import multicore_pkg::*;
#(
  parameter int unsigned WORDS = DEFAULT_WORDS,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        s_byte,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              output_write_done,
  output logic [WORD_W-1:0] com_data_in,
  output logic              data_write_start,
  output logic              data_write_done,
  output logic              frame_err,
  output logic              loaded
);

  load_state_t       state;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              full;
  logic              phase;
  logic [7:0]        hi_byte;
  logic              go_ok;

  logic              accept_c;
  logic              wr_en_c;
  logic [WORD_W-1:0] wr_word_c;
  logic              rd_en_c;
  logic [AW-1:0]     rd_addr_c;
  logic              go_c;

`ifdef LOAD_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic [WORD_W-1:0] ck_rx;
`endif

  // Handshake, buffer port and launch-permission decodes.
  always_comb begin
    accept_c  = (state == RECV) && s_valid && s_ready;
    wr_word_c = {hi_byte, s_byte};
    wr_en_c   = accept_c && phase && !full;
    rd_en_c   = (state == START) || ((state == BURST) && !data_write_done);
    rd_addr_c = (state == START) ? '0 : rd_ptr;
    // A readout-done pulse in the deciding cycle counts immediately.
    go_c      = go_ok || output_write_done;
  end

  load_buffer #(
    .WORDS (WORDS),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (wr_word_c),
    .rd_en   (rd_en_c),
    .rd_addr (rd_addr_c),
    .rd_data (com_data_in)
  );

`ifndef LOAD_CHECKSUM_EN
  assign frame_err = 1'b0;
`endif

  // Loader FSM with its pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= RECV;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      full             <= 1'b0;
      phase            <= 1'b0;
      hi_byte          <= '0;
      go_ok            <= 1'b1;
      s_ready          <= 1'b0;
      data_write_start <= 1'b0;
      data_write_done  <= 1'b0;
      loaded           <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
      sum              <= '0;
      ck_rx            <= '0;
      frame_err        <= 1'b0;
`endif
    end else begin
      // START consumes permission even if a done pulse lands in the same cycle.
      if (state == START) begin
        go_ok <= 1'b0;
      end else if (output_write_done) begin
        go_ok <= 1'b1;
      end

      data_write_start <= 1'b0;

      case (state)
        RECV: begin
          s_ready <= 1'b1;
          if (accept_c) begin
            phase <= ~phase;
            if (!phase) begin
              hi_byte <= s_byte;
            end
            if (wr_en_c) begin
              wr_ptr <= wr_ptr + AW'(1);
`ifdef LOAD_CHECKSUM_EN
              sum    <= sum + wr_word_c;
`endif
              if (wr_ptr == AW'(WORDS - 1)) begin
                full <= 1'b1;
`ifndef LOAD_CHECKSUM_EN
                s_ready <= 1'b0;
                loaded  <= 1'b1;
                if (go_c) begin
                  state            <= START;
                  data_write_start <= 1'b1;
                end else begin
                  state <= HOLD;
                end
`endif
              end
            end
`ifdef LOAD_CHECKSUM_EN
            else if (full && phase) begin
              ck_rx   <= wr_word_c;
              s_ready <= 1'b0;
              state   <= CHECK;
            end
`endif
          end
        end

`ifdef LOAD_CHECKSUM_EN
        CHECK: begin
          if (sum == ck_rx) begin
            frame_err <= 1'b0;
            loaded    <= 1'b1;
            state     <= HOLD;
          end else begin
            frame_err <= 1'b1;
            wr_ptr    <= '0;
            full      <= 1'b0;
            phase     <= 1'b0;
            sum       <= '0;
            s_ready   <= 1'b1;
            state     <= RECV;
          end
        end
`endif

        HOLD: begin
          if (go_c) begin
            state            <= START;
            data_write_start <= 1'b1;
          end
        end

        START: begin
          loaded <= 1'b0;
          rd_ptr <= AW'(1);
          state  <= BURST;
        end

        BURST: begin
          if (data_write_done) begin
            data_write_done <= 1'b0;
            s_ready         <= 1'b1;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            full            <= 1'b0;
            phase           <= 1'b0;
`ifdef LOAD_CHECKSUM_EN
            sum             <= '0;
`endif
            state           <= RECV;
          end else begin
            rd_ptr <= rd_ptr + AW'(1);
            if (rd_ptr == AW'(WORDS - 1)) begin
              data_write_done <= 1'b1;
            end
          end
        end

        default: begin
          state <= RECV;
        end
      endcase
    end
  end

endmodule
